// File: rtl/reg_file.sv
// reg_file: two-read, one-write register file.
// r0 is hardwired to zero; optional same-cycle write bypass.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic BYP = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;
  logic              hit1;
  logic              hit2;

  assign wr_en = reg_write && (write_reg != '0);

  // Clear everything on reset; otherwise store to any nonzero address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[write_reg] <= write_data;
    end
  end

  assign hit1 = BYP && wr_en
             && (read_reg1 == write_reg);
  assign hit2 = BYP && wr_en
             && (read_reg2 == write_reg);

  // Port 1: zero under reset or r0, bypass on hit, else stored.
  always_comb begin
    read_data1 = '0;
    if (rst || read_reg1 == '0) begin
      read_data1 = '0;
    end else if (hit1) begin
      read_data1 = write_data;
    end else begin
      read_data1 = regs[read_reg1];
    end
  end

  // Port 2: evaluated independently of port 1.
  always_comb begin
    read_data2 = '0;
    if (rst || read_reg2 == '0) begin
      read_data2 = '0;
    end else if (hit2) begin
      read_data2 = write_data;
    end else begin
      read_data2 = regs[read_reg2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file.
// Runs a bypass and a non-bypass instance on shared stimulus.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] b_d1, b_d2;
  logic [31:0] n_d1, n_d2;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data),
    .reg_write(reg_write),
    .read_data1(b_d1), .read_data2(b_d2)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data),
    .reg_write(reg_write),
    .read_data1(n_d1), .read_data2(n_d2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] b1;
    logic [31:0] b2;
    logic [31:0] n1;
    logic [31:0] n2;
  } exp_t;

  exp_t q[$];
  logic strobe = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: pop each expectation when the stimulus presents outputs.
  always @(strobe) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (b_d1 !== e.b1 || b_d2 !== e.b2 ||
          n_d1 !== e.n1 || n_d2 !== e.n2) begin
        miscompares++;
        $display("FAIL %s: got byp=%h/%h nobyp=%h/%h want byp=%h/%h nobyp=%h/%h",
                 e.name, b_d1, b_d2, n_d1, n_d2,
                 e.b1, e.b2, e.n1, e.n2);
      end
    end
  end

  task automatic expect4(input string nm,
                         input logic [31:0] b1,
                         input logic [31:0] b2,
                         input logic [31:0] n1,
                         input logic [31:0] n2);
    exp_t e;
    #1;
    e.name = nm;
    e.b1 = b1; e.b2 = b2;
    e.n1 = n1; e.n2 = n2;
    q.push_back(e);
    strobe = ~strobe;
    #1;
  endtask

  task automatic expect2(input string nm,
                         input logic [31:0] d1,
                         input logic [31:0] d2);
    expect4(nm, d1, d2, d1, d2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    reg_write = 1'b1;
    write_reg = a;
    write_data = d;
    tick();
    reg_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    read_reg1 = 5'd5;
    read_reg2 = 5'd31;
    write_reg = '0;
    write_data = '0;
    reg_write = 1'b0;
    expect2("reset_state", 32'h0, 32'h0);
    tick();
    rst = 1'b0;

    wr(5'd5, 32'hDEADBEEF);
    read_reg1 = 5'd5;
    read_reg2 = 5'd5;
    expect2("r5_loaded", 32'hDEADBEEF, 32'hDEADBEEF);

    rst = 1'b1;
    expect2("rst_async", 32'h0, 32'h0);
    reg_write = 1'b1;
    write_reg = 5'd5;
    write_data = 32'd7;
    expect2("rst_no_bypass", 32'h0, 32'h0);
    tick();
    reg_write = 1'b0;
    rst = 1'b0;
    expect2("rst_write_dropped", 32'h0, 32'h0);

    wr(5'd8, 32'd8);
    wr(5'd4, 32'd4);
    read_reg1 = 5'd8;
    read_reg2 = 5'd4;
    expect2("basic_8_4", 32'd8, 32'd4);

    reg_write = 1'b1;
    write_reg = 5'd0;
    write_data = 32'hFFFFFFFF;
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    expect2("r0_during_write", 32'h0, 32'h0);
    tick();
    reg_write = 1'b0;
    expect2("r0_after_write", 32'h0, 32'h0);

    wr(5'd3, 32'd10);
    reg_write = 1'b1;
    write_reg = 5'd3;
    write_data = 32'd20;
    read_reg1 = 5'd3;
    read_reg2 = 5'd4;
    expect4("bypass_before", 32'd20, 32'd4,
            32'd10, 32'd4);
    tick();
    reg_write = 1'b0;
    expect2("bypass_after", 32'd20, 32'd4);

    wr(5'd31, 32'h12345678);
    read_reg1 = 5'd31;
    read_reg2 = 5'd31;
    expect2("dual_31", 32'h12345678, 32'h12345678);
    write_data = 32'h0;
    expect2("dual_wd_0", 32'h12345678, 32'h12345678);
    write_data = 32'hFFFFFFFF;
    expect2("dual_wd_f", 32'h12345678, 32'h12345678);
    tick();
    expect2("dual_hold", 32'h12345678, 32'h12345678);

    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i * 3));
    end
    for (int i = 1; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(32 - i);
      expect2($sformatf("sweep_%0d", i),
              32'(i * 3), 32'((32 - i) * 3));
    end
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    expect2("sweep_r0", 32'h0, 32'h0);

    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
